// File: rtl/fpu_pkg.sv
// Shared FP32 field layout and divider FSM encoding for the FPU datapath.
package fpu_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned SIG_W   = 24;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned BIAS    = 127;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } div_state_e;

endpackage

// File: rtl/fpu_div_step.sv
// One combinational restoring-division step: trial subtract, quotient bit, shift.
module fpu_div_step #(
  parameter int unsigned REM_W = 26,
  parameter int unsigned SIG_W = 24
) (
  input  logic [REM_W-1:0] i_rem,
  input  logic [SIG_W-1:0] i_div,
  output logic [REM_W-1:0] o_rem,
  output logic             o_q
);

  logic [REM_W:0]   w_trial;
  logic [REM_W-1:0] w_keep;

  always_comb begin
    w_trial = {1'b0, i_rem} - {{(REM_W + 1 - SIG_W){1'b0}}, i_div};
    o_q     = ~w_trial[REM_W];
    w_keep  = o_q ? w_trial[REM_W-1:0] : i_rem;
    o_rem   = {w_keep[REM_W-2:0], 1'b0};
  end

endmodule

// File: rtl/fpu_32_divider.sv
// Iterative FP32 divider, one quotient bit per clock, valid/ready on both sides.
// Define FPU_DIV_ROUND_EN for a guard step and round-to-nearest-even; default truncates.
module fpu_32_divider
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        div_by_zero_flag
);

`ifdef FPU_DIV_ROUND_EN
  localparam int unsigned Q_W = SIG_W + 2;
`else
  localparam int unsigned Q_W = SIG_W + 1;
`endif
  localparam int unsigned REM_W    = SIG_W + 2;
  localparam logic [4:0]  CNT_INIT = 5'(Q_W - 1);

  div_state_e         r_state, w_state_d;
  logic               r_sign;
  logic [EXP_W-1:0]   r_ex, r_ey;
  logic [SIG_W-1:0]   r_my;
  logic [REM_W-1:0]   r_rem, w_rem_nxt;
  logic [Q_W-1:0]     r_q;
  logic [4:0]         r_cnt;
  logic [31:0]        r_res;
  logic               r_ovf, r_unf, r_dbz;
  logic               w_qbit, w_accept, w_x_zero, w_y_zero, w_sign_in, w_rnd;
  logic signed [9:0]  w_exp;
  logic [MANT_W-1:0]  w_mant;
  logic [MANT_W:0]    w_mant_rnd;

  assign w_accept  = in_valid & (r_state == IDLE);
  assign w_x_zero  = (X[30:0] == 31'd0);
  assign w_y_zero  = (Y[30:0] == 31'd0);
  assign w_sign_in = X[31] ^ Y[31];

  assign in_ready         = (r_state == IDLE);
  assign out_valid        = (r_state == DONE);
  assign res              = r_res;
  assign overflow_flag    = r_ovf;
  assign underflow_flag   = r_unf;
  assign div_by_zero_flag = r_dbz;

  fpu_div_step #(
    .REM_W(REM_W),
    .SIG_W(SIG_W)
  ) u_step (
    .i_rem(r_rem),
    .i_div(r_my),
    .o_rem(w_rem_nxt),
    .o_q  (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_d = (w_x_zero || w_y_zero) ? DONE : DIVIDE;
      DIVIDE:  if (r_cnt == 5'd0) w_state_d = NORM;
      NORM:    w_state_d = DONE;
      DONE:    if (out_ready) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Single-bit normalisation: the quotient of two normal significands lies in (0.5, 2).
  always_comb begin
    w_exp = $signed({2'b00, r_ex}) - $signed({2'b00, r_ey}) + $signed(10'(BIAS));
    w_rnd = 1'b0;
    if (r_q[Q_W-1]) begin
      w_mant = r_q[Q_W-2 -: MANT_W];
    end else begin
      w_mant = r_q[Q_W-3 -: MANT_W];
      w_exp  = w_exp - 10'sd1;
    end
`ifdef FPU_DIV_ROUND_EN
    // The bit dropped by a top-bit normalisation joins the sticky set.
    w_rnd = (r_q[Q_W-1] ? r_q[1] : r_q[0])
          & ((r_q[Q_W-1] & r_q[0]) | (|r_rem) | w_mant[0]);
`endif
    w_mant_rnd = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_rnd};
    if (w_mant_rnd[MANT_W]) w_exp = w_exp + 10'sd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_ex   <= '0;
      r_ey   <= '0;
      r_my   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_sign <= w_sign_in;
          r_ex   <= X[30:23];
          r_ey   <= Y[30:23];
          r_my   <= {|Y[30:23], Y[22:0]};
          r_rem  <= {2'b00, |X[30:23], X[22:0]};
          r_q    <= '0;
          r_cnt  <= CNT_INIT;
          r_ovf  <= 1'b0;
          r_unf  <= 1'b0;
          r_dbz  <= ~w_x_zero & w_y_zero;
          if (w_x_zero)      r_res <= 32'd0;
          else if (w_y_zero) r_res <= {w_sign_in, 8'hFF, 23'd0};
        end
        DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[Q_W-2:0], w_qbit};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        NORM: begin
          if (w_exp >= $signed(10'(EXP_MAX))) begin
            r_res <= {r_sign, 8'hFF, 23'd0};
            r_ovf <= 1'b1;
          end else if (w_exp <= 10'sd0) begin
            r_res <= {r_sign, 31'd0};
            r_unf <= 1'b1;
          end else begin
            r_res <= {r_sign, w_exp[7:0], w_mant_rnd[MANT_W-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_32_divider.sv
// Directed-vector bench for fpu_32_divider; expected values computed by hand.
module tb_fpu_32_divider;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        ovf, unf, dbz;
  logic [31:0] x, y, res;
  int          n_vec = 0;
  int          n_err = 0;

`ifdef FPU_DIV_ROUND_EN
  localparam int          LAT   = 27;
  localparam logic [31:0] R_1_15 = 32'h3F2AAAAB;
  localparam logic [31:0] R_1_3  = 32'h3EAAAAAB;
`else
  localparam int          LAT   = 26;
  localparam logic [31:0] R_1_15 = 32'h3F2AAAAA;
  localparam logic [31:0] R_1_3  = 32'h3EAAAAAA;
`endif

  always #5 clk = ~clk;

  fpu_32_divider dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .X               (x),
    .Y               (y),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .res             (res),
    .overflow_flag   (ovf),
    .underflow_flag  (unf),
    .div_by_zero_flag(dbz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, ovf, unf, dbz};
  endfunction

  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
  endtask

  // flag vector is {ovf, unf, dbz}
  task automatic finish_op(input string tag, input logic [31:0] exp_res,
                           input logic [2:0] exp_flg, input int exp_lat, input int hold);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " res"}, res, exp_res);
    check({tag, " flags"}, flags(), {29'd0, exp_flg});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      x = 32'h3F800000;
      y = 32'h40000000;
      @(posedge clk);
      #1;
      check({tag, " hold res"}, res, exp_res);
      check({tag, " hold flags"}, flags(), {29'd0, exp_flg});
      check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready rise"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    #12;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset res", res, 32'd0);
    check("reset flags", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op("3/1.5", 32'h40400000, 32'h3FC00000);
    finish_op("3/1.5", 32'h40000000, 3'b000, LAT, 0);
    start_op("1/1.5", 32'h3F800000, 32'h3FC00000);
    finish_op("1/1.5", R_1_15, 3'b000, LAT, 0);
    start_op("1/3", 32'h3F800000, 32'h40400000);
    finish_op("1/3", R_1_3, 3'b000, LAT, 0);
    start_op("6/-2", 32'h40C00000, 32'hC0000000);
    finish_op("6/-2", 32'hC0400000, 3'b000, LAT, 0);
    start_op("-1/0", 32'hBF800000, 32'h00000000);
    finish_op("-1/0", 32'hFF800000, 3'b001, 0, 0);
    start_op("0/2", 32'h00000000, 32'h40000000);
    finish_op("0/2", 32'h00000000, 3'b000, 0, 0);
    start_op("0/-0", 32'h00000000, 32'h80000000);
    finish_op("0/-0", 32'h00000000, 3'b000, 0, 0);
    start_op("underflow", 32'h00800000, 32'h7F000000);
    finish_op("underflow", 32'h00000000, 3'b010, LAT, 0);
    start_op("hold", 32'h40400000, 32'h3FC00000);
    finish_op("hold", 32'h40000000, 3'b000, LAT, 10);
    start_op("overflow", 32'h7F000000, 32'h00800000);
    finish_op("overflow", 32'h7F800000, 3'b100, LAT, 0);

    // Abort mid-divide once the counter has stepped down to 12.
    start_op("abort", 32'h40400000, 32'h3FC00000);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort res", res, 32'd0);
    check("abort flags", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op("post-abort", 32'h3F800000, 32'h40400000);
    finish_op("post-abort", R_1_3, 3'b000, LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
